// File: rtl/elevator_call_scheduler.sv
// SCAN-policy call scheduler: latches floor calls, issues up/down targets, retires calls on arrival.
// Optional WAIT watchdog with sticky fault flag is built when SCHED_WATCHDOG_EN is defined.
module elevator_call_scheduler #(
  parameter int NUM_FLOORS  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [3:0]            cur_floor,
  input  logic                  arrived,
  input  logic                  sleepmode,
  output logic [3:0]            floor_sel,
  output logic                  up,
  output logic                  down,
  output logic                  busy,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  fault
);

  typedef enum logic [1:0] {IDLE, WAIT, SLEEP} state_t;

  state_t                state;
  logic                  dir;
  logic [NUM_FLOORS-1:0] cur_mask;
  logic [NUM_FLOORS-1:0] sel_mask;
  logic [NUM_FLOORS-1:0] pend_nxt;
  logic                  have_above;
  logic                  have_below;
  logic                  have_mid;
  logic                  sel_valid;
  logic                  sel_dir;
  logic                  hit_target;
  logic                  wd_fire;
  logic [3:0]            above_fl;
  logic [3:0]            below_fl;
  logic [3:0]            mid_fl;
  logic [3:0]            sel_fl;

  // One-hot views of the car floor and the target; out-of-range floors match no bit.
  always_comb begin
    cur_mask = '0;
    sel_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      cur_mask[i] = (4'(i) == cur_floor);
      sel_mask[i] = (4'(i) == floor_sel);
    end
  end

  // Nearest pending floor on each side of the car (last match in each loop is the nearest).
  always_comb begin
    have_above = 1'b0;
    above_fl   = '0;
    have_below = 1'b0;
    below_fl   = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (4'(i) > cur_floor)) begin
        have_above = 1'b1;
        above_fl   = 4'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (4'(i) < cur_floor)) begin
        have_below = 1'b1;
        below_fl   = 4'(i);
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_fl    = '0;
    sel_dir   = dir;
    if (dir) begin
      if (have_above) begin
        sel_valid = 1'b1;
        sel_fl    = above_fl;
      end else if (have_below) begin
        sel_valid = 1'b1;
        sel_fl    = below_fl;
        sel_dir   = 1'b0;
      end
    end else begin
      if (have_below) begin
        sel_valid = 1'b1;
        sel_fl    = below_fl;
      end else if (have_above) begin
        sel_valid = 1'b1;
        sel_fl    = above_fl;
        sel_dir   = 1'b1;
      end
    end
  end

  // Retarget candidate: nearest pending floor strictly between the car and the current target.
  always_comb begin
    have_mid = 1'b0;
    mid_fl   = '0;
    if (dir) begin
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
        if (pending[i] && (4'(i) > cur_floor) && (4'(i) < floor_sel)) begin
          have_mid = 1'b1;
          mid_fl   = 4'(i);
        end
      end
    end else begin
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (pending[i] && (4'(i) < cur_floor) && (4'(i) > floor_sel)) begin
          have_mid = 1'b1;
          mid_fl   = 4'(i);
        end
      end
    end
  end

  assign hit_target = arrived && (cur_floor == floor_sel);
  assign busy       = (state == WAIT);

`ifdef SCHED_WATCHDOG_EN
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] wd_cnt;

  assign wd_fire = (state == WAIT) && !sleepmode && !hit_target && !have_mid &&
                   (wd_cnt == CW'(TIMEOUT_CYC - 1));

  // Counter restarts whenever a fresh target is issued; passing stops do not touch it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
      fault  <= 1'b0;
    end else begin
      if ((state != WAIT) || have_mid) wd_cnt <= '0;
      else                             wd_cnt <= wd_cnt + 1'b1;
      if (wd_fire) fault <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign fault   = 1'b0;
`endif

  // Later rules override earlier ones: clear beats call, sleep wipes everything.
  always_comb begin
    pend_nxt = pending | call_req;
    if (state == IDLE) pend_nxt = pending | (call_req & ~cur_mask);
    if (arrived)       pend_nxt = pend_nxt & ~cur_mask;
    if (wd_fire)       pend_nxt = pend_nxt & ~sel_mask;
    if (sleepmode || (state == SLEEP)) pend_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dir       <= 1'b1;
      floor_sel <= '0;
      up        <= 1'b0;
      down      <= 1'b0;
      pending   <= '0;
    end else begin
      pending <= pend_nxt;
      up      <= 1'b0;
      down    <= 1'b0;
      if (sleepmode) begin
        state <= SLEEP;
      end else begin
        case (state)
          IDLE: begin
            if (sel_valid) begin
              floor_sel <= sel_fl;
              dir       <= sel_dir;
              if (sel_fl > cur_floor) up   <= 1'b1;
              else                    down <= 1'b1;
              state <= WAIT;
            end
          end
          WAIT: begin
            if (hit_target) begin
              state <= IDLE;
            end else if (have_mid) begin
              floor_sel <= mid_fl;
              if (dir) up   <= 1'b1;
              else     down <= 1'b1;
            end else if (wd_fire) begin
              state <= IDLE;
            end
          end
          SLEEP:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Self-checking bench for elevator_call_scheduler: directed scenarios plus a randomized run
// against a floor-search reference model.
module tb_elevator_call_scheduler;

  localparam int NUM = 4;
  localparam int TMO = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NUM-1:0] call_req = '0;
  logic [3:0]     cur_floor = '0;
  logic           arrived = 1'b0;
  logic           sleepmode = 1'b0;
  logic [3:0]     floor_sel;
  logic           up;
  logic           down;
  logic           busy;
  logic [NUM-1:0] pending;
  logic           fault;

  int total = 0;
  int bad   = 0;

  // Reference model state: set of pending floors, travel sense, target, mode flags.
  bit m_pend [NUM];
  bit m_wait;
  bit m_sleep;
  bit m_dir_up;
  int m_target;
  bit m_up;
  bit m_down;
  bit m_fault;
  int m_age;

  elevator_call_scheduler #(.NUM_FLOORS(NUM), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .call_req(call_req), .cur_floor(cur_floor),
    .arrived(arrived), .sleepmode(sleepmode), .floor_sel(floor_sel), .up(up),
    .down(down), .busy(busy), .pending(pending), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; call_req = '0; cur_floor = '0; arrived = 1'b0; sleepmode = 1'b0;
    cycle();
    reset = 1'b0;
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_step();
    bit np [NUM];
    int cf, above, below, mid, sel;
    bit idle;
    cf = int'(cur_floor);
    if (reset) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_wait = 0; m_sleep = 0; m_dir_up = 1; m_target = 0;
      m_up = 0; m_down = 0; m_fault = 0; m_age = 0;
      return;
    end
    above = -1;
    for (int f = cf + 1; f < NUM; f++) if (m_pend[f] && above < 0) above = f;
    below = -1;
    for (int f = cf - 1; f >= 0; f--) if (f < NUM && m_pend[f] && below < 0) below = f;
    mid = -1;
    if (m_dir_up) begin
      for (int f = cf + 1; f < m_target; f++) if (f < NUM && m_pend[f] && mid < 0) mid = f;
    end else begin
      for (int f = cf - 1; f > m_target; f--) if (f < NUM && m_pend[f] && mid < 0) mid = f;
    end
    idle = !m_wait && !m_sleep;
    for (int i = 0; i < NUM; i++) np[i] = m_pend[i] || (call_req[i] && !(idle && i == cf));
    if (arrived && cf < NUM) np[cf] = 1'b0;
    m_up = 0; m_down = 0;
    if (sleepmode) begin
      m_sleep = 1; m_wait = 0;
      foreach (np[i]) np[i] = 1'b0;
    end else if (m_sleep) begin
      m_sleep = 0;
      foreach (np[i]) np[i] = 1'b0;
    end else if (idle) begin
      sel = -1;
      if (m_dir_up) begin
        if (above >= 0) sel = above;
        else if (below >= 0) begin sel = below; m_dir_up = 0; end
      end else begin
        if (below >= 0) sel = below;
        else if (above >= 0) begin sel = above; m_dir_up = 1; end
      end
      if (sel >= 0) begin
        m_target = sel;
        if (sel > cf) m_up = 1; else m_down = 1;
        m_wait = 1; m_age = 0;
      end
    end else begin
      if (arrived && cf == m_target) m_wait = 0;
      else if (mid >= 0) begin
        m_target = mid;
        if (m_dir_up) m_up = 1; else m_down = 1;
        m_age = 0;
      end
`ifdef SCHED_WATCHDOG_EN
      else begin
        m_age++;
        if (m_age == TMO) begin
          np[m_target] = 1'b0; m_fault = 1; m_wait = 0;
        end
      end
`endif
    end
    foreach (m_pend[i]) m_pend[i] = np[i];
  endtask

  task automatic test_reset();
    reset = 1'b1; call_req = 4'b1111; cur_floor = 4'd0;
    cycle();
    total++; if (pending !== 4'b0000) begin bad++; $display("[TB] FAIL reset_pending got=%b want=0000", pending); end
    total++; if ({up, down, busy, fault} !== 4'b0000) begin bad++; $display("[TB] FAIL reset_flags got=%b want=0000", {up, down, busy, fault}); end
    total++; if (floor_sel !== 4'd0) begin bad++; $display("[TB] FAIL reset_floor_sel got=%0d want=0", floor_sel); end
    reset = 1'b0; call_req = 4'b0010;
    cycle();
    call_req = '0;
    cycle();
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL reset_prewait_busy got=%b want=1", busy); end
    reset = 1'b1;
    cycle();
    total++; if ({busy, floor_sel, pending} !== 9'd0) begin bad++; $display("[TB] FAIL reset_midwait got=%b want=0", {busy, floor_sel, pending}); end
    reset = 1'b0;
  endtask

  task automatic test_dispatch();
    do_reset();
    call_req = 4'b0100;
    cycle();
    call_req = '0;
    total++; if (pending !== 4'b0100) begin bad++; $display("[TB] FAIL dispatch_pending got=%b want=0100", pending); end
    total++; if ({up, busy} !== 2'b00) begin bad++; $display("[TB] FAIL dispatch_early got=%b want=00", {up, busy}); end
    cycle();
    total++; if (floor_sel !== 4'd2) begin bad++; $display("[TB] FAIL dispatch_floor got=%0d want=2", floor_sel); end
    total++; if ({up, down, busy} !== 3'b101) begin bad++; $display("[TB] FAIL dispatch_pulse got=%b want=101", {up, down, busy}); end
    cycle();
    total++; if ({up, down} !== 2'b00) begin bad++; $display("[TB] FAIL dispatch_width got=%b want=00", {up, down}); end
    cur_floor = 4'd2; arrived = 1'b1;
    cycle();
    arrived = 1'b0;
    total++; if ({busy, pending} !== 5'b0) begin bad++; $display("[TB] FAIL dispatch_retire got=%b want=00000", {busy, pending}); end
  endtask

  task automatic test_scan_reverse();
    do_reset();
    cur_floor = 4'd1; call_req = 4'b1001;
    cycle();
    call_req = '0;
    total++; if (pending !== 4'b1001) begin bad++; $display("[TB] FAIL scan_pending got=%b want=1001", pending); end
    cycle();
    total++; if ({floor_sel, up, down} !== {4'd3, 2'b10}) begin bad++; $display("[TB] FAIL scan_first got=%0d/%b%b want=3/10", floor_sel, up, down); end
    cur_floor = 4'd3; arrived = 1'b1;
    cycle();
    arrived = 1'b0;
    total++; if ({busy, pending} !== 5'b00001) begin bad++; $display("[TB] FAIL scan_arrive got=%b want=00001", {busy, pending}); end
    cycle();
    total++; if ({floor_sel, up, down, busy} !== {4'd0, 3'b011}) begin bad++; $display("[TB] FAIL scan_reverse got=%0d/%b%b%b want=0/011", floor_sel, up, down, busy); end
  endtask

  task automatic test_retarget();
    do_reset();
    cur_floor = 4'd0; call_req = 4'b1000;
    cycle();
    call_req = '0;
    cycle();
    total++; if ({floor_sel, up} !== {4'd3, 1'b1}) begin bad++; $display("[TB] FAIL retarget_first got=%0d/%b want=3/1", floor_sel, up); end
    call_req = 4'b0100;
    cycle();
    call_req = '0;
    total++; if ({pending, up, floor_sel} !== {4'b1100, 1'b0, 4'd3}) begin bad++; $display("[TB] FAIL retarget_latch got=%b want=1100_0_0011", {pending, up, floor_sel}); end
    cycle();
    total++; if ({floor_sel, up, down, busy} !== {4'd2, 3'b101}) begin bad++; $display("[TB] FAIL retarget_reload got=%0d/%b%b%b want=2/101", floor_sel, up, down, busy); end
    cycle();
    total++; if (up !== 1'b0) begin bad++; $display("[TB] FAIL retarget_width got=%b want=0", up); end
    cur_floor = 4'd2; arrived = 1'b1;
    cycle();
    arrived = 1'b0;
    total++; if ({busy, pending} !== 5'b01000) begin bad++; $display("[TB] FAIL retarget_arrive got=%b want=01000", {busy, pending}); end
    cycle();
    total++; if ({floor_sel, up} !== {4'd3, 1'b1}) begin bad++; $display("[TB] FAIL retarget_reissue got=%0d/%b want=3/1", floor_sel, up); end
  endtask

  task automatic test_clear_wins();
    do_reset();
    cur_floor = 4'd1; call_req = 4'b1000;
    cycle();
    call_req = '0;
    cycle();
    call_req = 4'b0010; arrived = 1'b1;
    cycle();
    call_req = '0; arrived = 1'b0;
    total++; if ({pending, busy} !== 5'b10001) begin bad++; $display("[TB] FAIL clear_wins got=%b want=10001", {pending, busy}); end
    cur_floor = 4'd3; arrived = 1'b1;
    cycle();
    arrived = 1'b0; call_req = 4'b1000;
    cycle();
    call_req = '0;
    total++; if (pending !== 4'b0000) begin bad++; $display("[TB] FAIL idle_own_floor got=%b want=0000", pending); end
    cycle();
    total++; if ({busy, up, down} !== 3'b000) begin bad++; $display("[TB] FAIL idle_no_issue got=%b want=000", {busy, up, down}); end
  endtask

  task automatic test_sleep();
    do_reset();
    cur_floor = 4'd0; call_req = 4'b0110;
    cycle();
    call_req = '0;
    cycle();
    total++; if ({floor_sel, busy, pending} !== {4'd1, 1'b1, 4'b0110}) begin bad++; $display("[TB] FAIL sleep_setup got=%b want=0001_1_0110", {floor_sel, busy, pending}); end
    sleepmode = 1'b1; call_req = 4'b1000; arrived = 1'b1;
    cycle();
    arrived = 1'b0;
    total++; if ({pending, up, down, busy} !== 7'b0) begin bad++; $display("[TB] FAIL sleep_enter got=%b want=0000000", {pending, up, down, busy}); end
    total++; if (floor_sel !== 4'd1) begin bad++; $display("[TB] FAIL sleep_hold got=%0d want=1", floor_sel); end
    cycle();
    total++; if ({pending, up, down} !== 6'b0) begin bad++; $display("[TB] FAIL sleep_ignore got=%b want=000000", {pending, up, down}); end
    sleepmode = 1'b0; call_req = '0;
    cycle();
    cycle();
    total++; if ({busy, up, down, pending} !== 7'b0) begin bad++; $display("[TB] FAIL sleep_exit got=%b want=0000000", {busy, up, down, pending}); end
  endtask

`ifdef SCHED_WATCHDOG_EN
  task automatic test_watchdog();
    int early;
    do_reset();
    cur_floor = 4'd0; call_req = 4'b1000;
    cycle();
    call_req = '0;
    cycle();
    early = 0;
    for (int i = 0; i < TMO - 1; i++) begin
      cycle();
      if (busy !== 1'b1 || fault !== 1'b0) early++;
    end
    total++; if (early != 0) begin bad++; $display("[TB] FAIL wd_early got=%0d want=0", early); end
    cycle();
    total++; if ({busy, fault, pending} !== 6'b010000) begin bad++; $display("[TB] FAIL wd_fire got=%b want=010000", {busy, fault, pending}); end
    cycle();
    total++; if ({fault, up, down} !== 3'b100) begin bad++; $display("[TB] FAIL wd_sticky got=%b want=100", {fault, up, down}); end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    total++; if (fault !== 1'b0) begin bad++; $display("[TB] FAIL wd_reset got=%b want=0", fault); end
  endtask
`endif

  task automatic test_random();
    logic [NUM-1:0] exp_pend;
    reset = 1'b1;
    model_step();
    cycle();
    reset = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NUM; i++) call_req[i] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 0) cur_floor = 4'(m_target);
      else cur_floor = 4'($urandom_range(0, NUM));
      arrived   = ($urandom_range(0, 2) == 0);
      sleepmode = ($urandom_range(0, 29) == 0);
      model_step();
      cycle();
      for (int i = 0; i < NUM; i++) exp_pend[i] = m_pend[i];
      total++; if (pending !== exp_pend) begin bad++; $display("[TB] FAIL rand_pending n=%0d got=%b want=%b", n, pending, exp_pend); end
      total++; if (floor_sel !== 4'(m_target)) begin bad++; $display("[TB] FAIL rand_floor_sel n=%0d got=%0d want=%0d", n, floor_sel, m_target); end
      total++; if ({up, down} !== {m_up, m_down}) begin bad++; $display("[TB] FAIL rand_pulse n=%0d got=%b%b want=%b%b", n, up, down, m_up, m_down); end
      total++; if ({busy, fault} !== {m_wait, m_fault}) begin bad++; $display("[TB] FAIL rand_status n=%0d got=%b%b want=%b%b", n, busy, fault, m_wait, m_fault); end
    end
    reset = 1'b0; call_req = '0; arrived = 1'b0; sleepmode = 1'b0;
  endtask

  initial begin
    $display("[TB] starting elevator_call_scheduler bench");
    test_reset();
    test_dispatch();
    test_scan_reverse();
    test_retarget();
    test_clear_wins();
    test_sleep();
`ifdef SCHED_WATCHDOG_EN
    test_watchdog();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
